// File: rtl/comb_truth_table_checker_if.sv
// Bundle between the truth-table checker and its environment: sweep control,
// golden table, stimulus/response to the gate network, and sweep results.
interface comb_truth_table_checker_if #(
  parameter int N_IN = 3
);
  logic                 start_i;
  logic [2**N_IN-1:0]   expected_i;
  logic                 resp_i;
  logic [N_IN-1:0]      stim_o;
  logic                 stim_valid_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 pass_o;
  logic [N_IN:0]        err_cnt_o;
  logic [N_IN-1:0]      first_err_o;
  logic                 first_err_vld_o;

  modport master (
    input  start_i, expected_i, resp_i,
    output stim_o, stim_valid_o, busy_o, done_o, pass_o,
           err_cnt_o, first_err_o, first_err_vld_o
  );

  modport slave (
    output start_i, expected_i, resp_i,
    input  stim_o, stim_valid_o, busy_o, done_o, pass_o,
           err_cnt_o, first_err_o, first_err_vld_o
  );
endinterface

// File: rtl/comb_truth_table_checker.sv
// Sweeps all 2^N_IN vectors (HOLD cycles each) into a combinational block and checks its
// response against a table latched at start; done_o pulses 2^N_IN*HOLD+1 cycles after start, no backpressure.
module comb_truth_table_checker #(
  parameter int N_IN = 3,
  parameter int HOLD = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  comb_truth_table_checker_if.master bus
);
  localparam int NVEC = 2**N_IN;
  localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] STIM_MAX  = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [NVEC-1:0]   exp_q, exp_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   ferr_q, ferr_d;
  logic              fvld_q, fvld_d;
  logic              mismatch;

  always_comb begin
    // An unknown response fails the equality test and so counts as a mismatch.
    mismatch = 1'b1;
    if (bus.resp_i == exp_q[stim_q]) mismatch = 1'b0;

    state_d = state_q;
    exp_d   = exp_q;
    stim_d  = stim_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    fvld_d  = fvld_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          exp_d   = bus.expected_i;
          stim_d  = '0;
          hold_d  = '0;
          err_d   = '0;
          ferr_d  = '0;
          fvld_d  = 1'b0;
          pass_d  = 1'b0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hold_q == HOLD_LAST) begin
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!fvld_q) begin
              ferr_d = stim_q;
              fvld_d = 1'b1;
            end
          end
          if (stim_q == STIM_MAX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            stim_d = stim_q + 1'b1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      DONE: begin
        pass_d  = (err_q == '0);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      stim_q  <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '0;
      fvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      stim_q  <= stim_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      fvld_q  <= fvld_d;
    end
  end

  assign bus.stim_o          = stim_q;
  assign bus.stim_valid_o    = valid_q;
  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.pass_o          = pass_q;
  assign bus.err_cnt_o       = err_q;
  assign bus.first_err_o     = ferr_q;
  assign bus.first_err_vld_o = fvld_q;
endmodule

// File: tb/tb_comb_truth_table_checker.sv
// Bench for two checker configurations (N_IN=3/HOLD=2 and N_IN=4/HOLD=1) with a
// result queue per instance, popped by a monitor on every done_o pulse.
module tb_comb_truth_table_checker;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [1:0] mode3;

  typedef struct {
    int err;
    int first;
    int fvld;
    int pass;
    int cyc;
  } exp_t;

  exp_t q3[$];
  exp_t q4[$];

  comb_truth_table_checker_if #(.N_IN(3)) b3();
  comb_truth_table_checker_if #(.N_IN(4)) b4();

  comb_truth_table_checker #(.N_IN(3), .HOLD(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  comb_truth_table_checker #(.N_IN(4), .HOLD(1)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  // mode3: 0 = gate network f, 1 = tied high, 2 = tied low
  assign b3.resp_i = (mode3 == 2'd0) ?
                     (!(b3.stim_o[2] & b3.stim_o[1]) | (b3.stim_o[2] & b3.stim_o[1] & !b3.stim_o[0])) :
                     (mode3 == 2'd1);
  assign b4.resp_i = ^b4.stim_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin : mon3
    exp_t e;
    forever begin
      @(negedge clk);
      if (b3.done_o === 1'b1) begin
        if (q3.size() == 0) begin
          chk("n3_spurious_done", q3.size(), 1);
        end else begin
          e = q3.pop_front();
          chk("n3_done_cycle", cyc, e.cyc);
          chk("n3_err_cnt", int'(b3.err_cnt_o), e.err);
          chk("n3_first_err", int'(b3.first_err_o), e.first);
          chk("n3_first_err_vld", int'(b3.first_err_vld_o), e.fvld);
          chk("n3_busy_in_done", int'(b3.busy_o), 1);
          chk("n3_valid_in_done", int'(b3.stim_valid_o), 0);
          @(negedge clk);
          chk("n3_pass", int'(b3.pass_o), e.pass);
          chk("n3_busy_after", int'(b3.busy_o), 0);
          chk("n3_done_pulse", int'(b3.done_o), 0);
        end
      end
    end
  end

  initial begin : mon4
    exp_t e;
    forever begin
      @(negedge clk);
      if (b4.done_o === 1'b1) begin
        if (q4.size() == 0) begin
          chk("n4_spurious_done", q4.size(), 1);
        end else begin
          e = q4.pop_front();
          chk("n4_done_cycle", cyc, e.cyc);
          chk("n4_err_cnt", int'(b4.err_cnt_o), e.err);
          chk("n4_first_err_vld", int'(b4.first_err_vld_o), e.fvld);
          @(negedge clk);
          chk("n4_pass", int'(b4.pass_o), e.pass);
          chk("n4_done_pulse", int'(b4.done_o), 0);
        end
      end
    end
  end

  // Pulses start on instance 3; expected done cycle is start-edge + 8*2 + 1.
  task automatic start3(input logic [7:0] tbl, input logic [1:0] md, input bit push,
                        input int err, input int first, input int fvld, input int pass);
    exp_t e;
    @(negedge clk);
    b3.expected_i = tbl;
    mode3         = md;
    b3.start_i    = 1'b1;
    if (push) begin
      e.err = err; e.first = first; e.fvld = fvld; e.pass = pass; e.cyc = cyc + 17;
      q3.push_back(e);
    end
    @(negedge clk);
    b3.start_i = 1'b0;
  endtask

  task automatic wait_q3();
    for (int t = 0; t < 300 && q3.size() != 0; t++) @(negedge clk);
    chk("n3_sweep_timeout", q3.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_stim3(input int v);
    int t;
    t = 0;
    while (t < 400 && !(b3.stim_valid_o === 1'b1 && int'(b3.stim_o) == v)) begin
      @(negedge clk);
      t++;
    end
    chk("n3_reach_vector", int'(b3.stim_o), v);
  endtask

  task automatic chk_zero3(input string tag);
    chk({tag, "_stim"},      int'(b3.stim_o), 0);
    chk({tag, "_valid"},     int'(b3.stim_valid_o), 0);
    chk({tag, "_busy"},      int'(b3.busy_o), 0);
    chk({tag, "_done"},      int'(b3.done_o), 0);
    chk({tag, "_pass"},      int'(b3.pass_o), 0);
    chk({tag, "_err_cnt"},   int'(b3.err_cnt_o), 0);
    chk({tag, "_first_err"}, int'(b3.first_err_o), 0);
    chk({tag, "_first_vld"}, int'(b3.first_err_vld_o), 0);
  endtask

  initial begin : stim
    exp_t e;
    int n;
    rst_n         = 1'b0;
    mode3         = 2'd0;
    b3.start_i    = 1'b0;
    b3.expected_i = 8'h00;
    b4.start_i    = 1'b0;
    b4.expected_i = 16'h0000;
    repeat (3) @(negedge clk);
    chk_zero3("reset");
    chk("reset_n4_busy", int'(b4.busy_o), 0);
    rst_n = 1'b1;

    // Clean sweep; stim_o walks 0..7 holding each vector for two cycles.
    start3(8'h7F, 2'd0, 1'b1, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      chk("n3_walk_stim", int'(b3.stim_o), k / 2);
      chk("n3_walk_valid", int'(b3.stim_valid_o), 1);
      @(negedge clk);
    end
    wait_q3();

    start3(8'h7F, 2'd1, 1'b1, 1, 7, 1, 0);
    wait_q3();
    start3(8'h7F, 2'd2, 1'b1, 7, 0, 1, 0);
    wait_q3();
    start3(8'hFF, 2'd2, 1'b1, 8, 0, 1, 0);
    wait_q3();

    // Start re-pulsed and table corrupted mid-sweep: neither may disturb the run.
    start3(8'h7F, 2'd0, 1'b1, 0, 0, 0, 1);
    wait_stim3(4);
    b3.start_i    = 1'b1;
    b3.expected_i = 8'h00;
    @(negedge clk);
    b3.start_i = 1'b0;
    wait_q3();

    // Reset at vector 5 aborts without a done pulse; a fresh sweep is then clean.
    start3(8'h7F, 2'd0, 1'b0, 0, 0, 0, 0);
    wait_stim3(5);
    rst_n = 1'b0;
    #1;
    chk_zero3("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk_zero3("after_abort");
    start3(8'h7F, 2'd0, 1'b1, 0, 0, 0, 1);
    wait_q3();

    // N_IN=4, HOLD=1 parity network with start held across two sweeps.
    @(negedge clk);
    n = cyc;
    b4.expected_i = 16'h6996;
    b4.start_i    = 1'b1;
    e.err = 0; e.first = 0; e.fvld = 0; e.pass = 1; e.cyc = n + 17;
    q4.push_back(e);
    e.cyc = n + 35;
    q4.push_back(e);
    repeat (19) @(negedge clk);
    b4.start_i = 1'b0;
    for (int t = 0; t < 300 && q4.size() != 0; t++) @(negedge clk);
    chk("n4_sweep_timeout", q4.size(), 0);
    repeat (40) @(negedge clk);
    chk("n4_idle_at_end", int'(b4.busy_o), 0);
    chk("n3_queue_drained", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
